// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, with a combinational busy so the core stalls in the accept cycle.
module ex_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_bi,
  input  logic [WIDTH-1:0] b_bi,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [1:0]         opReg;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic               isDiv;
  logic               divZero;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remShift;
  logic [WIDTH-1:0]   remDiff;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   runResult;

  assign isDiv   = opReg[1];
  assign divZero = op_i[1] && (b_bi == '0);

  // acc holds {partial product, remaining multiplier} for multiply and
  // {partial remainder, dividend bits shifting into quotient} for divide.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    remDiff  = remShift[WIDTH-1:0] - opnd;
    accNext  = {mulSum, acc[WIDTH-1:1]};
    if (isDiv) begin
      if (remShift >= {1'b0, opnd}) begin
        accNext = {remDiff, acc[WIDTH-2:0], 1'b1};
      end else begin
        accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // op bit 0 selects the upper half: MULHU high word, REMU remainder.
  assign runResult = opReg[0] ? accNext[2*WIDTH-1:WIDTH] : accNext[WIDTH-1:0];

  assign busy_o = !rst_i && (((state == IDLE) && start_i) || (state == RUN));
  assign done_o = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      opReg    <= '0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            opReg <= op_i;
            cnt   <= '0;
            if (op_i[1]) begin
              opnd <= b_bi;
              acc  <= {{WIDTH{1'b0}}, a_bi};
            end else begin
              opnd <= a_bi;
              acc  <= {{WIDTH{1'b0}}, b_bi};
            end
            if (divZero) begin
              result_o <= op_i[0] ? a_bi : '1;
              state    <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= accNext;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            result_o <= runResult;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Bench for ex_muldiv_iter: directed vector table, back-to-back and reset
// sequences, then random operations against a plain-arithmetic reference.
module tb_ex_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        startI;
  logic [1:0]  opI;
  logic [31:0] aBi;
  logic [31:0] bBi;
  logic        busyO;
  logic        doneO;
  logic [31:0] resultO;

  int nVec = 0;
  int nMis = 0;
  int cyc  = 0;

  ex_muldiv_iter #(.WIDTH(32), .CNT_W(5)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (startI),
    .op_i    (opI),
    .a_bi    (aBi),
    .b_bi    (bBi),
    .busy_o  (busyO),
    .done_o  (doneO),
    .result_o(resultO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLat(input logic [1:0] op, input logic [31:0] b);
    return (op >= 2 && b == 0) ? 1 : 33;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns in the DONE cycle with start still high.
  task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat, output int busyCnt,
                      output logic busyInDone);
    startI = 1'b1;
    opI    = op;
    aBi    = b == b ? a : a;
    bBi    = b;
    lat     = 0;
    busyCnt = 0;
    #1;
    while (!doneO && lat < 100) begin
      if (busyO) busyCnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    res        = resultO;
    busyInDone = busyO;
  endtask

  // Drop the request after DONE and confirm nothing relaunches and the result holds.
  task automatic endOp(input string name, input logic [31:0] exp);
    startI = 1'b0;
    @(posedge clk);
    #1;
    check({name, " idle done"}, {63'd0, doneO}, 64'd0);
    check({name, " idle busy"}, {63'd0, busyO}, 64'd0);
    check({name, " held result"}, {32'd0, resultO}, {32'd0, exp});
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          busyCnt;
    logic        busyDone;
    int          doneCyc1;
    int          doneCyc2;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0] = '{2'd0, 32'd7,          32'd6,          32'd42,         33};
    tbl[1] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
    tbl[2] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33};
    tbl[3] = '{2'd2, 32'd100,        32'd7,          32'd14,         33};
    tbl[4] = '{2'd3, 32'd100,        32'd7,          32'd2,          33};
    tbl[5] = '{2'd2, 32'd5,          32'd9,          32'd0,          33};
    tbl[6] = '{2'd3, 32'hFFFF_FFFF,  32'd1,          32'd0,          33};
    tbl[7] = '{2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    tbl[8] = '{2'd3, 32'd5,          32'd0,          32'd5,          1};

    rst    = 1'b1;
    startI = 1'b0;
    opI    = 2'd0;
    aBi    = '0;
    bBi    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", {32'd0, resultO}, 64'd0);
    check("reset done", {63'd0, doneO}, 64'd0);
    startI = 1'b1;
    #1;
    check("reset busy with start", {63'd0, busyO}, 64'd0);
    startI = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      doOp(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, busyCnt, busyDone);
      check($sformatf("vec%0d result", i), {32'd0, res}, {32'd0, tbl[i].exp});
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("vec%0d busy cycles", i), 64'(busyCnt), 64'(tbl[i].lat));
      check($sformatf("vec%0d busy in done", i), {63'd0, busyDone}, 64'd0);
      endOp($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Back-to-back: start stays high into the IDLE cycle after DONE.
    doOp(2'd0, 32'd3, 32'd4, res, lat, busyCnt, busyDone);
    doneCyc1 = cyc;
    check("b2b first result", {32'd0, res}, 64'd12);
    @(posedge clk);
    #1;
    doOp(2'd2, 32'd12, 32'd5, res, lat, busyCnt, busyDone);
    doneCyc2 = cyc;
    check("b2b second result", {32'd0, res}, 64'd2);
    check("b2b done spacing", 64'(doneCyc2 - doneCyc1), 64'd34);
    endOp("b2b", 32'd2);

    // Asynchronous reset in the middle of a multiply, start held through release.
    startI = 1'b1;
    opI    = 2'd0;
    aBi    = 32'd9;
    bBi    = 32'd9;
    repeat (10) @(posedge clk);
    #1;
    check("mid-op busy before reset", {63'd0, busyO}, 64'd1);
    rst = 1'b1;
    #1;
    check("async reset busy", {63'd0, busyO}, 64'd0);
    check("async reset result", {32'd0, resultO}, 64'd0);
    check("async reset done", {63'd0, doneO}, 64'd0);
    aBi = 32'd2;
    bBi = 32'd3;
    @(posedge clk);
    #1;
    check("held reset busy", {63'd0, busyO}, 64'd0);
    rst = 1'b0;
    doOp(2'd0, 32'd2, 32'd3, res, lat, busyCnt, busyDone);
    check("post-reset result", {32'd0, res}, 64'd6);
    check("post-reset latency", 64'(lat), 64'd33);
    endOp("post-reset", 32'd6);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      doOp(rop, ra, rb, res, lat, busyCnt, busyDone);
      check($sformatf("rnd%0d op%0d a=%0h b=%0h result", i, rop, ra, rb),
            {32'd0, res}, {32'd0, refResult(rop, ra, rb)});
      check($sformatf("rnd%0d latency", i), 64'(lat), 64'(refLat(rop, rb)));
      endOp($sformatf("rnd%0d", i), refResult(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
